// File: rtl/cpu_register_file_multiport_if.sv
// cpu_register_file_multiport_if
//   Bus bundle between the CPU pipeline and the multiport register file.
//   Parameters:
//     DATA_WIDTH  bits per register
//     ADDR_WIDTH  register address width
//   Signals:
//     ready_out                   file has finished its post-reset clear
//     write_enable0_in / write_register_address0_in / write_data0_in   write lane 0
//     write_enable1_in / write_register_address1_in / write_data1_in   write lane 1 (wins on same address)
//     read_enable1_in / read_register_address1_in / read_data1_out     read port 1
//     read_enable2_in / read_register_address2_in / read_data2_out     read port 2
//   Modports:
//     master  CPU side (decode + writeback)
//     slave   register file side
interface cpu_register_file_multiport_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  ready_out;
  logic                  write_enable0_in;
  logic [ADDR_WIDTH-1:0] write_register_address0_in;
  logic [DATA_WIDTH-1:0] write_data0_in;
  logic                  write_enable1_in;
  logic [ADDR_WIDTH-1:0] write_register_address1_in;
  logic [DATA_WIDTH-1:0] write_data1_in;
  logic                  read_enable1_in;
  logic [ADDR_WIDTH-1:0] read_register_address1_in;
  logic [DATA_WIDTH-1:0] read_data1_out;
  logic                  read_enable2_in;
  logic [ADDR_WIDTH-1:0] read_register_address2_in;
  logic [DATA_WIDTH-1:0] read_data2_out;

  modport master (
    input  ready_out, read_data1_out, read_data2_out,
    output write_enable0_in, write_register_address0_in, write_data0_in,
    output write_enable1_in, write_register_address1_in, write_data1_in,
    output read_enable1_in, read_register_address1_in,
    output read_enable2_in, read_register_address2_in
  );

  modport slave (
    output ready_out, read_data1_out, read_data2_out,
    input  write_enable0_in, write_register_address0_in, write_data0_in,
    input  write_enable1_in, write_register_address1_in, write_data1_in,
    input  read_enable1_in, read_register_address1_in,
    input  read_enable2_in, read_register_address2_in
  );
endinterface

// File: rtl/cpu_register_file_multiport.sv
// cpu_register_file_multiport
//   Two-write / two-read CPU register file. Reads are registered (latency 1)
//   and see the writes of the same edge (lane 1 over lane 0 over stored value).
//   After reset every register is cleared one per cycle; ready_out stays low
//   until the clear has walked all NUMBER_OF_REGISTERS entries, and all
//   reads/writes are ignored meanwhile.
//   Parameters:
//     DATA_WIDTH           bits per register
//     NUMBER_OF_REGISTERS  register count (>= 2), need not be a power of two
//   Ports:
//     clock_in   single clock, all state on posedge
//     reset_in   synchronous, active-high
//     bus        cpu_register_file_multiport_if.slave (write lanes, read ports, ready_out)
//   Build option:
//     REGFILE_ZERO_REGISTER_EN  register 0 hardwired to zero (writes dropped, reads 0)
module cpu_register_file_multiport #(
  parameter int DATA_WIDTH          = 8,
  parameter int NUMBER_OF_REGISTERS = 256
) (
  input logic                          clock_in,
  input logic                          reset_in,
  cpu_register_file_multiport_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(NUMBER_OF_REGISTERS);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX     = ADDR_WIDTH'(NUMBER_OF_REGISTERS - 1);
  localparam logic [ADDR_WIDTH:0]   REGISTER_COUNT = (ADDR_WIDTH + 1)'(NUMBER_OF_REGISTERS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clear_count;
  logic                  ready;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [DATA_WIDTH-1:0] registers [NUMBER_OF_REGISTERS];

  logic [ADDR_WIDTH-1:0] write_address0;
  logic [ADDR_WIDTH-1:0] write_address1;
  logic [DATA_WIDTH-1:0] write_data0;
  logic [DATA_WIDTH-1:0] write_data1;
  logic                  write0_valid;
  logic                  write1_valid;
  logic                  write0_shadowed;
  logic [DATA_WIDTH-1:0] forward1;
  logic [DATA_WIDTH-1:0] forward2;

  // An address is usable only if it names a real register; with the zero
  // register enabled, address 0 is treated as unusable so that writes to it
  // vanish and reads of it return zero through the same path.
  function automatic logic address_usable(input logic [ADDR_WIDTH-1:0] address);
    logic usable;
    usable = ({1'b0, address} < REGISTER_COUNT);
`ifdef REGFILE_ZERO_REGISTER_EN
    usable = usable && (address != '0);
`else
    usable = usable && 1'b1;
`endif
    return usable;
  endfunction

  // Value a register will hold after this edge's writes have landed.
  function automatic logic [DATA_WIDTH-1:0] value_after_writes(input logic [ADDR_WIDTH-1:0] address);
    if (!address_usable(address))
      return '0;
    if (write1_valid && (write_address1 == address))
      return write_data1;
    if (write0_valid && (write_address0 == address))
      return write_data0;
    return registers[address];
  endfunction

  assign write_address0 = bus.write_register_address0_in;
  assign write_address1 = bus.write_register_address1_in;
  assign write_data0    = bus.write_data0_in;
  assign write_data1    = bus.write_data1_in;

  // Lane qualification and same-address arbitration (lane 1 wins).
  always_comb begin
    write0_valid    = bus.write_enable0_in && address_usable(write_address0);
    write1_valid    = bus.write_enable1_in && address_usable(write_address1);
    write0_shadowed = write1_valid && (write_address1 == write_address0);
    forward1        = value_after_writes(bus.read_register_address1_in);
    forward2        = value_after_writes(bus.read_register_address2_in);
  end

  // Clear sequencer and READY-state storage/read capture in one state machine.
  // The storage array is not reset directly; the CLEAR walk initialises it.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state       <= CLEAR;
      clear_count <= '0;
      ready       <= 1'b0;
      read_data1  <= '0;
      read_data2  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          registers[clear_count] <= '0;
          clear_count            <= clear_count + 1'b1;
          if (clear_count == LAST_INDEX) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (write1_valid)
            registers[write_address1] <= write_data1;
          if (write0_valid && !write0_shadowed)
            registers[write_address0] <= write_data0;
          if (bus.read_enable1_in)
            read_data1 <= forward1;
          if (bus.read_enable2_in)
            read_data2 <= forward2;
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out      = ready;
  assign bus.read_data1_out = read_data1;
  assign bus.read_data2_out = read_data2;
endmodule

// File: tb/tb_cpu_register_file_multiport.sv
// tb_cpu_register_file_multiport
//   Self-checking bench for cpu_register_file_multiport (DATA_WIDTH=8,
//   NUMBER_OF_REGISTERS=256). Table of directed vectors, hand sequences for
//   the clear/reset corner cases, and random traffic against an array model.
//   Honours REGFILE_ZERO_REGISTER_EN the same way the design does.
module tb_cpu_register_file_multiport;
  localparam int NR = 256;

`ifdef REGFILE_ZERO_REGISTER_EN
  localparam logic [7:0] ZERO_REG_VALUE = 8'h00;
  localparam bit         ZERO_HARDWIRED = 1'b1;
`else
  localparam logic [7:0] ZERO_REG_VALUE = 8'h7E;
  localparam bit         ZERO_HARDWIRED = 1'b0;
`endif

  typedef struct {
    logic       we0;
    logic [7:0] a0;
    logic [7:0] d0;
    logic       we1;
    logic [7:0] a1;
    logic [7:0] d1;
    logic       re1;
    logic [7:0] ra1;
    logic       re2;
    logic [7:0] ra2;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vector_t;

  logic clock_in = 1'b0;
  logic reset_in;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [NR];
  logic [7:0] model_rd1;
  logic [7:0] model_rd2;

  cpu_register_file_multiport_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  cpu_register_file_multiport #(
    .DATA_WIDTH(8),
    .NUMBER_OF_REGISTERS(NR)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .bus(bus)
  );

  always #5 clock_in = ~clock_in;

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                               input logic we1, input logic [7:0] a1, input logic [7:0] d1,
                               input logic re1, input logic [7:0] ra1,
                               input logic re2, input logic [7:0] ra2);
    stim_t s;
    s.we0 = we0; s.a0 = a0; s.d0 = d0;
    s.we1 = we1; s.a1 = a1; s.d1 = d1;
    s.re1 = re1; s.ra1 = ra1;
    s.re2 = re2; s.ra2 = ra2;
    return s;
  endfunction

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0)
      return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 7));
  endfunction

  function automatic stim_t random_stim();
    return mk(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), rand_addr(),
              1'($urandom_range(0, 1)), rand_addr());
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_inputs(input stim_t s);
    bus.write_enable0_in           = s.we0;
    bus.write_register_address0_in = s.a0;
    bus.write_data0_in             = s.d0;
    bus.write_enable1_in           = s.we1;
    bus.write_register_address1_in = s.a1;
    bus.write_data1_in             = s.d1;
    bus.read_enable1_in            = s.re1;
    bus.read_register_address1_in  = s.ra1;
    bus.read_enable2_in            = s.re2;
    bus.read_register_address2_in  = s.ra2;
  endtask

  task automatic step();
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  // Reference: apply lane 0 then lane 1 to the array (lane 1 overwrites on a
  // shared address), then reads see the updated array.
  task automatic model_update(input stim_t s);
    if (s.we0 && !(ZERO_HARDWIRED && s.a0 == 8'd0))
      model_mem[s.a0] = s.d0;
    if (s.we1 && !(ZERO_HARDWIRED && s.a1 == 8'd0))
      model_mem[s.a1] = s.d1;
    if (s.re1)
      model_rd1 = model_mem[s.ra1];
    if (s.re2)
      model_rd2 = model_mem[s.ra2];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++)
      model_mem[i] = 8'h00;
    model_rd1 = 8'h00;
    model_rd2 = 8'h00;
  endtask

  task automatic apply_stimulus(input stim_t s);
    drive_inputs(s);
    model_update(s);
    step();
  endtask

  task automatic apply_and_check(input stim_t s, input string tag);
    apply_stimulus(s);
    check_output({tag, " rd1"}, 32'(bus.read_data1_out), 32'(model_rd1));
    check_output({tag, " rd2"}, 32'(bus.read_data2_out), 32'(model_rd2));
    check_output({tag, " ready"}, 32'(bus.ready_out), 32'd1);
  endtask

  // Releases reset and runs up to 'limit' cycles of clear while hammering
  // both write lanes (lane 0 always targets address 3) and both read ports.
  // Returns the cycle on which ready_out was first seen high, or -1.
  task automatic run_clear(input int limit, output int ready_cycle);
    stim_t s;
    reset_in    = 1'b0;
    ready_cycle = -1;
    for (int k = 1; k <= limit; k++) begin
      s     = random_stim();
      s.we0 = 1'b1;
      s.a0  = 8'd3;
      s.d0  = 8'h77;
      s.re1 = 1'b1;
      s.re2 = 1'b1;
      drive_inputs(s);
      step();
      check_output("clear rd1", 32'(bus.read_data1_out), 32'd0);
      check_output("clear rd2", 32'(bus.read_data2_out), 32'd0);
      if (bus.ready_out === 1'b1) begin
        ready_cycle = k;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    drive_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_in = 1'b1;
    step();
    check_output("reset ready", 32'(bus.ready_out), 32'd0);
    check_output("reset rd1", 32'(bus.read_data1_out), 32'd0);
    check_output("reset rd2", 32'(bus.read_data2_out), 32'd0);
  endtask

  vector_t table_v [13];

  initial begin
    int ready_cycle;

    // Directed vectors, applied back to back straight after the first clear.
    table_v[0]  = '{mk(1, 8'd5, 8'h3C, 0, 8'd0, 8'h00, 0, 8'd0, 0, 8'd0), 8'h00, 8'h00};
    table_v[1]  = '{mk(0, 8'd0, 8'h00, 0, 8'd0, 8'h00, 1, 8'd5, 0, 8'd0), 8'h3C, 8'h00};
    table_v[2]  = '{mk(1, 8'd9, 8'h11, 1, 8'd9, 8'h22, 0, 8'd0, 1, 8'd9), 8'h3C, 8'h22};
    table_v[3]  = '{mk(0, 8'd0, 8'h00, 0, 8'd0, 8'h00, 1, 8'd9, 0, 8'd0), 8'h22, 8'h22};
    table_v[4]  = '{mk(1, 8'd7, 8'hA5, 0, 8'd0, 8'h00, 1, 8'd7, 1, 8'd7), 8'hA5, 8'hA5};
    table_v[5]  = '{mk(0, 8'd0, 8'h00, 0, 8'd0, 8'h00, 1, 8'd7, 1, 8'd5), 8'hA5, 8'h3C};
    table_v[6]  = '{mk(0, 8'd0, 8'h00, 1, 8'd0, 8'h7E, 1, 8'd0, 0, 8'd0), ZERO_REG_VALUE, 8'h3C};
    table_v[7]  = '{mk(0, 8'd0, 8'h00, 0, 8'd0, 8'h00, 1, 8'd0, 1, 8'd0), ZERO_REG_VALUE, ZERO_REG_VALUE};
    table_v[8]  = '{mk(1, 8'd20, 8'h44, 1, 8'd21, 8'h55, 1, 8'd20, 1, 8'd21), 8'h44, 8'h55};
    table_v[9]  = '{mk(0, 8'd0, 8'h00, 0, 8'd0, 8'h00, 1, 8'd21, 1, 8'd20), 8'h55, 8'h44};
    table_v[10] = '{mk(1, 8'd20, 8'h99, 0, 8'd0, 8'h00, 0, 8'd20, 0, 8'd20), 8'h55, 8'h44};
    table_v[11] = '{mk(0, 8'd0, 8'h00, 0, 8'd0, 8'h00, 1, 8'd20, 0, 8'd0), 8'h99, 8'h44};
    table_v[12] = '{mk(1, 8'd255, 8'h12, 0, 8'd0, 8'h00, 0, 8'd0, 1, 8'd255), 8'h99, 8'h12};

    reset_in = 1'b1;
    model_clear();
    step();

    // Power-up clear: ready exactly NR cycles after reset drops.
    pulse_reset();
    run_clear(400, ready_cycle);
    check_output("ready latency", 32'(ready_cycle), 32'(NR));
    model_clear();
    drive_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Fresh file reads zero, including both ends of the address range.
    apply_and_check(mk(0, 0, 0, 0, 0, 0, 1, 8'd0, 1, 8'd255), "post clear");
    apply_and_check(mk(0, 0, 0, 0, 0, 0, 1, 8'd3, 1, 8'd128), "post clear");

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(table_v[i].s);
      check_output($sformatf("vector %0d rd1", i), 32'(bus.read_data1_out), 32'(table_v[i].exp1));
      check_output($sformatf("vector %0d rd2", i), 32'(bus.read_data2_out), 32'(table_v[i].exp2));
    end

    for (int n = 0; n < 1500; n++)
      apply_and_check(random_stim(), "random");

    // Reset restarted part-way through clear; earlier and mid-clear writes vanish.
    apply_and_check(mk(1, 8'd3, 8'hFF, 0, 0, 0, 0, 0, 0, 0), "write addr3");
    apply_and_check(mk(0, 0, 0, 0, 0, 0, 1, 8'd3, 0, 0), "read addr3");
    pulse_reset();
    run_clear(10, ready_cycle);
    check_output("aborted clear ready", 32'(ready_cycle), 32'hFFFF_FFFF);
    pulse_reset();
    run_clear(400, ready_cycle);
    check_output("restart ready latency", 32'(ready_cycle), 32'(NR));
    model_clear();
    for (int a = 0; a < NR / 2; a++)
      apply_and_check(mk(0, 0, 0, 0, 0, 0, 1, 8'(a), 1, 8'(a + NR / 2)), "sweep");

    apply_and_check(mk(0, 0, 0, 0, 0, 0, 1, 8'd3, 0, 0), "addr3 after restart");
    check_output("addr3 cleared", 32'(bus.read_data1_out), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
